// File: rtl/riscv_pkg.sv
// Shared types and defaults for the pipelined RISC-V integer register file.
// Optional write-through forwarding is selected with RISCV_REGFILE_BYPASS_EN.
package riscv_pkg;

  localparam int unsigned XLEN_DEFAULT  = 32'd32;
  localparam int unsigned NREGS_DEFAULT = 32'd32;
  localparam int unsigned REG_ZERO      = 32'd0;

  typedef logic [4:0]  reg_addr_t;
  typedef logic [31:0] xword_t;

endpackage

// File: rtl/riscv_regfile_sb_chk.sv
// Invariant checker for the register file scoreboard; carries no design logic.
module riscv_regfile_sb_chk #(
  parameter int NREGS = 32
) (
  input logic             clk,
  input logic             rst,
  input logic [NREGS-1:0] busy_vec
);

  a_x0_never_busy: assert property (@(posedge clk) busy_vec[0] == 1'b0);

  a_rst_scoreboard_empty: assert property (@(posedge clk) rst |-> (busy_vec == {NREGS{1'b0}}));

endmodule

// File: rtl/riscv_rf_rdport.sv
// One combinational read port of the register file: stored-state mux plus,
// when RISCV_REGFILE_BYPASS_EN is defined, forwarding of the in-flight writeback.
module riscv_rf_rdport
  import riscv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int AW    = 5
) (
  input  logic [NREGS-1:0][XLEN-1:0] regs,
  input  logic [NREGS-1:0]           busy,
  input  logic [AW-1:0]              rd_addr,
  input  logic                       fwd_en,
  input  logic [AW-1:0]              wr_addr,
  input  logic [XLEN-1:0]            wr_data,
  input  logic                       fwd_busy,
  output logic [XLEN-1:0]            rd_data,
  output logic                       rd_busy
);

  localparam logic [AW-1:0] ZERO_ADDR = AW'(REG_ZERO);

  // Port read: x0 is forced to zero/idle, otherwise stored state or the forwarded write
  always_comb begin
    if (rd_addr == ZERO_ADDR) begin
      rd_data = {XLEN{1'b0}};
      rd_busy = 1'b0;
    end
`ifdef RISCV_REGFILE_BYPASS_EN
    else if (fwd_en && (rd_addr == wr_addr)) begin
      rd_data = wr_data;
      rd_busy = fwd_busy;
    end
`endif
    else begin
      rd_data = regs[rd_addr];
      rd_busy = busy[rd_addr];
    end
  end

`ifndef RISCV_REGFILE_BYPASS_EN
  logic unused_fwd_s;
  assign unused_fwd_s = ^{fwd_en, wr_addr, wr_data, fwd_busy};
`endif

endmodule

// File: rtl/riscv_regfile_sb.sv
// Parametrised integer register file with per-register busy scoreboard.
// Define RISCV_REGFILE_BYPASS_EN to forward same-cycle writeback to the read ports.
module riscv_regfile_sb
  import riscv_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int NREGS = NREGS_DEFAULT,
  parameter int NRD   = 2,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [XLEN-1:0]     wr_data,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic                sb_set_en,
  input  logic [AW-1:0]       sb_set_addr,
  output logic [NREGS-1:0]    busy_vec
);

  localparam logic [AW-1:0] ZERO_ADDR = AW'(REG_ZERO);

  logic [NREGS-1:0][XLEN-1:0] regs_r;
  logic [NREGS-1:0]           busy_r;
  logic [NREGS-1:0]           busy_nxt_s;
  logic [NREGS-1:0]           clr_mask_s;
  logic [NREGS-1:0]           set_mask_s;
  logic                       wr_we_s;
  logic                       sb_we_s;
  logic                       fwd_en_s;
  logic                       fwd_busy_s;

  // Address 0 is never a legal target for either a write or a scoreboard set
  assign wr_we_s    = wr_en && (wr_addr != ZERO_ADDR);
  assign sb_we_s    = sb_set_en && (sb_set_addr != ZERO_ADDR);
  assign fwd_en_s   = wr_we_s && !rst;
  assign fwd_busy_s = sb_we_s && (sb_set_addr == wr_addr);

  // Architectural storage; x0 is never written so it keeps its reset value of zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs_r <= {(NREGS*XLEN){1'b0}};
    end else if (wr_we_s) begin
      regs_r[wr_addr] <= wr_data;
    end
  end

  // Scoreboard update: writeback clears, issue sets, and a set on the same edge wins
  always_comb begin
    clr_mask_s = {NREGS{1'b0}};
    set_mask_s = {NREGS{1'b0}};
    for (int i = 0; i < NREGS; i++) begin
      clr_mask_s[i] = wr_we_s && (wr_addr == AW'(i));
      set_mask_s[i] = sb_we_s && (sb_set_addr == AW'(i));
    end
    busy_nxt_s = (busy_r & ~clr_mask_s) | set_mask_s;
  end

  // Scoreboard register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_r <= {NREGS{1'b0}};
    end else begin
      busy_r <= busy_nxt_s;
    end
  end

  assign busy_vec = busy_r;

  for (genvar g = 0; g < NRD; g++) begin : g_rdport
    riscv_rf_rdport #(
      .XLEN  (XLEN),
      .NREGS (NREGS),
      .AW    (AW)
    ) u_rdport (
      .regs     (regs_r),
      .busy     (busy_r),
      .rd_addr  (rd_addr[g*AW +: AW]),
      .fwd_en   (fwd_en_s),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .fwd_busy (fwd_busy_s),
      .rd_data  (rd_data[g*XLEN +: XLEN]),
      .rd_busy  (rd_busy[g])
    );
  end

  riscv_regfile_sb_chk #(
    .NREGS (NREGS)
  ) u_chk (
    .clk      (clk),
    .rst      (rst),
    .busy_vec (busy_r)
  );

endmodule
